// File: rtl/gpu_instruction_queue_decoder.sv
// Buffered GPU instruction decoder. It tracks the XY1, XY2 and colour shadow
// registers from the APB command stream and packs each draw opcode into a
// packet. Packets wait in a DEPTH-entry FIFO until the raster engine pops them.
//
// Handshake: a packet moves downstream on every rising edge where valid_o and
// ready_i are both high. valid_o stays high while the FIFO holds data. It never
// depends on ready_i. While valid_o && !ready_i the head fields hold stable.
// When the FIFO is empty, the head fields keep showing the last popped packet.
module gpu_instruction_queue_decoder #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 10,
  parameter int CHANNEL_BITS = 8,
  parameter int DEPTH        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                opcode_i,
  input  logic [24:0]               parameters_i,
  input  logic                      command_i,
  input  logic                      clr_err_i,
  output logic [WIDTH_BITS-1:0]     x1_o,
  output logic [HEIGHT_BITS-1:0]    y1_o,
  output logic [WIDTH_BITS-1:0]     x2_o,
  output logic [HEIGHT_BITS-1:0]    y2_o,
  output logic [WIDTH_BITS-1:0]     rad_o,
  output logic [CHANNEL_BITS-1:0]   r_o,
  output logic [CHANNEL_BITS-1:0]   g_o,
  output logic [CHANNEL_BITS-1:0]   b_o,
  output logic [1:0]                shape_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      busy_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      overflow_o,
  output logic                      illegal_o
);

  localparam int W  = WIDTH_BITS;
  localparam int H  = HEIGHT_BITS;
  localparam int C  = CHANNEL_BITS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [3:0] OP_SET_XY1     = 4'd1;
  localparam logic [3:0] OP_SET_XY2     = 4'd2;
  localparam logic [3:0] OP_SET_COLOR   = 4'd3;
  localparam logic [3:0] OP_DRAW_LINE   = 4'd4;
  localparam logic [3:0] OP_DRAW_CIRCLE = 4'd5;
  localparam logic [3:0] OP_FILL_RECT   = 4'd6;

  localparam logic [1:0] SHAPE_LINE   = 2'b00;
  localparam logic [1:0] SHAPE_CIRCLE = 2'b01;
  localparam logic [1:0] SHAPE_RECT   = 2'b10;

  if (W + H > 25) begin : g_bad_xy
    $error("WIDTH_BITS + HEIGHT_BITS must not exceed 25");
  end
  if (3 * C > 25) begin : g_bad_colour
    $error("3 * CHANNEL_BITS must not exceed 25");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [1:0]   shape;
    logic [W-1:0] x1;
    logic [H-1:0] y1;
    logic [W-1:0] x2;
    logic [H-1:0] y2;
    logic [W-1:0] rad;
    logic [C-1:0] r;
    logic [C-1:0] g;
    logic [C-1:0] b;
  } pkt_t;

  // Shadow registers
  logic [W-1:0] x1_q, x2_q;
  logic [H-1:0] y1_q, y2_q;
  logic [C-1:0] r_q, g_q, b_q;

  // FIFO state
  pkt_t          mem_q [DEPTH];
  pkt_t          last_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q;
  logic          overflow_q, illegal_q;

  // Decoded fields of the current payload
  logic [W-1:0] p_x, p_rad;
  logic [H-1:0] p_y;
  logic [C-1:0] p_r, p_g, p_b;
  logic         unused_payload;

  assign p_x   = parameters_i[W+H-1:H];
  assign p_y   = parameters_i[H-1:0];
  assign p_rad = parameters_i[W-1:0];
  assign p_r   = parameters_i[3*C-1:2*C];
  assign p_g   = parameters_i[2*C-1:C];
  assign p_b   = parameters_i[C-1:0];
  assign unused_payload = ^parameters_i;

  logic   is_draw, is_illegal, load_colour, do_push, do_pop, fifo_full;
  pkt_t   new_pkt;

  assign is_draw     = command_i && (opcode_i == OP_DRAW_LINE ||
                                     opcode_i == OP_DRAW_CIRCLE ||
                                     opcode_i == OP_FILL_RECT);
  assign is_illegal  = command_i && (opcode_i > OP_FILL_RECT);
  assign load_colour = command_i && (opcode_i == OP_SET_COLOR ||
                                     opcode_i == OP_DRAW_LINE ||
                                     opcode_i == OP_FILL_RECT);
  assign fifo_full   = (count_q == FULL_COUNT);
  assign do_pop      = (count_q != '0) && ready_i;
  // A full FIFO can still accept a push when the same edge frees a slot.
  assign do_push     = is_draw && (!fifo_full || do_pop);

  // Build the packet from the shadow values as they stood before this edge
  always_comb begin
    new_pkt       = '0;
    new_pkt.x1    = x1_q;
    new_pkt.y1    = y1_q;
    new_pkt.x2    = x2_q;
    new_pkt.y2    = y2_q;
    new_pkt.shape = SHAPE_LINE;
    new_pkt.r     = p_r;
    new_pkt.g     = p_g;
    new_pkt.b     = p_b;
    if (opcode_i == OP_DRAW_CIRCLE) begin
      new_pkt.shape = SHAPE_CIRCLE;
      new_pkt.rad   = p_rad;
      new_pkt.r     = r_q;
      new_pkt.g     = g_q;
      new_pkt.b     = b_q;
    end else if (opcode_i == OP_FILL_RECT) begin
      new_pkt.shape = SHAPE_RECT;
    end
  end

  // Next occupancy from the push/pop pair
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Shadow register updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
      r_q  <= '0; g_q  <= '0; b_q  <= '0;
    end else begin
      if (command_i && opcode_i == OP_SET_XY1) begin
        x1_q <= p_x;
        y1_q <= p_y;
      end
      if (command_i && opcode_i == OP_SET_XY2) begin
        x2_q <= p_x;
        y2_q <= p_y;
      end
      if (load_colour) begin
        r_q <= p_r;
        g_q <= p_g;
        b_q <= p_b;
      end
    end
  end

  // FIFO storage, pointers, occupancy and the last-popped copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= new_pkt;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      busy_q  <= (count_d == FULL_COUNT);
    end
  end

  // Sticky error flags; a new event wins over a clear on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (is_draw && !do_push) overflow_q <= 1'b1;
      else if (clr_err_i)      overflow_q <= 1'b0;
      if (is_illegal)          illegal_q  <= 1'b1;
      else if (clr_err_i)      illegal_q  <= 1'b0;
    end
  end

  pkt_t head;
  assign head = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;

  assign x1_o       = head.x1;
  assign y1_o       = head.y1;
  assign x2_o       = head.x2;
  assign y2_o       = head.y2;
  assign rad_o      = head.rad;
  assign r_o        = head.r;
  assign g_o        = head.g;
  assign b_o        = head.b;
  assign shape_o    = head.shape;
  assign valid_o    = (count_q != '0);
  assign busy_o     = busy_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_gpu_instruction_queue_decoder.sv
// Directed bench for gpu_instruction_queue_decoder with the default parameters
// (10-bit x/y, 8-bit channels, 4-entry FIFO).
module tb_gpu_instruction_queue_decoder;

  logic        tb_clk;
  logic        rst;
  logic [3:0]  opcode_i;
  logic [24:0] parameters_i;
  logic        command_i;
  logic        clr_err_i;
  logic [9:0]  x1_o, x2_o, rad_o;
  logic [9:0]  y1_o, y2_o;
  logic [7:0]  r_o, g_o, b_o;
  logic [1:0]  shape_o;
  logic        valid_o, ready_i, busy_o;
  logic [2:0]  count_o;
  logic        overflow_o, illegal_o;

  int checks = 0;
  int errors = 0;

  gpu_instruction_queue_decoder dut (
    .clk(tb_clk), .rst(rst), .opcode_i(opcode_i), .parameters_i(parameters_i),
    .command_i(command_i), .clr_err_i(clr_err_i),
    .x1_o(x1_o), .y1_o(y1_o), .x2_o(x2_o), .y2_o(y2_o), .rad_o(rad_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o), .shape_o(shape_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .count_o(count_o),
    .overflow_o(overflow_o), .illegal_o(illegal_o)
  );

  // Clock
  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // One command strobe covering exactly one rising edge; returns at a negedge
  task automatic issue(input logic [3:0] op, input logic [24:0] p);
    @(negedge tb_clk);
    opcode_i     = op;
    parameters_i = p;
    command_i    = 1'b1;
    @(negedge tb_clk);
    command_i    = 1'b0;
    opcode_i     = 4'd0;
    parameters_i = '0;
  endtask

  // Hold ready_i for n rising edges, starting and ending at a negedge
  task automatic pop_cycles(input int n);
    ready_i = 1'b1;
    repeat (n) @(negedge tb_clk);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    ready_i = 1'b0;
    issue(4'd2, 25'h01807);
    issue(4'd4, 25'h0ABD3E);
    issue(4'd4, 25'h010203);
    issue(4'd9, 25'h0);
    issue(4'd4, 25'h040506);
    checks++;
    if (count_o !== 3'd3 || illegal_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: count=%0d illegal=%b, need count=3 illegal=1", count_o, illegal_o);
    end
    rst = 1'b1;
    @(negedge tb_clk);
    rst = 1'b0;
    checks++;
    if (count_o !== 3'd0 || valid_o !== 1'b0 || busy_o !== 1'b0 ||
        overflow_o !== 1'b0 || illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: count=%0d valid=%b busy=%b ovf=%b ill=%b, need all 0",
               count_o, valid_o, busy_o, overflow_o, illegal_o);
    end
    checks++;
    if ({x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o, shape_o} !== '0) begin
      errors++;
      $display("FAIL reset_fields: x2=%0d y2=%0d r=%h g=%h b=%h shape=%b, need all 0",
               x2_o, y2_o, r_o, g_o, b_o, shape_o);
    end
    // XY2 shadow must also be cleared by reset
    issue(4'd6, 25'h0);
    checks++;
    if (valid_o !== 1'b1 || shape_o !== 2'b10 || x2_o !== 10'd0 || y2_o !== 10'd0) begin
      errors++;
      $display("FAIL reset_shadow: valid=%b shape=%b x2=%0d y2=%0d, need 1 10 0 0",
               valid_o, shape_o, x2_o, y2_o);
    end
    pop_cycles(1);
  endtask

  task automatic test_basic_line();
    issue(4'd1, 25'h0);
    issue(4'd2, 25'h01807);
    issue(4'd4, 25'h0ABD3E);
    checks++;
    if (valid_o !== 1'b1 || shape_o !== 2'b00 || x1_o !== 10'd0 || y1_o !== 10'd0 ||
        x2_o !== 10'd6 || y2_o !== 10'd7 || rad_o !== 10'd0 ||
        r_o !== 8'h0A || g_o !== 8'hBD || b_o !== 8'h3E) begin
      errors++;
      $display("FAIL basic_line: v=%b sh=%b x1=%0d y1=%0d x2=%0d y2=%0d rad=%0d rgb=%h%h%h, need 1 00 0 0 6 7 0 0abd3e",
               valid_o, shape_o, x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o);
    end
    pop_cycles(1);
    checks++;
    if (valid_o !== 1'b0 || count_o !== 3'd0 || b_o !== 8'h3E || x2_o !== 10'd6) begin
      errors++;
      $display("FAIL stale_head: valid=%b count=%0d b=%h x2=%0d, need 0 0 3e 6",
               valid_o, count_o, b_o, x2_o);
    end
  endtask

  task automatic test_circle();
    issue(4'd3, 25'h112233);
    issue(4'd1, 25'h01409);
    issue(4'd5, 25'd20);
    checks++;
    if (valid_o !== 1'b1 || shape_o !== 2'b01 || x1_o !== 10'd5 || y1_o !== 10'd9 ||
        x2_o !== 10'd6 || y2_o !== 10'd7 || rad_o !== 10'd20 ||
        r_o !== 8'h11 || g_o !== 8'h22 || b_o !== 8'h33) begin
      errors++;
      $display("FAIL circle: v=%b sh=%b x1=%0d y1=%0d x2=%0d y2=%0d rad=%0d rgb=%h%h%h, need 1 01 5 9 6 7 20 112233",
               valid_o, shape_o, x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o);
    end
    pop_cycles(1);
  endtask

  task automatic test_fill_overflow();
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) issue(4'd4, 25'(i));
    checks++;
    if (busy_o !== 1'b1 || count_o !== 3'd4 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_4: busy=%b count=%0d ovf=%b, need 1 4 0", busy_o, count_o, overflow_o);
    end
    issue(4'd4, 25'd5);
    checks++;
    if (busy_o !== 1'b1 || count_o !== 3'd4 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow: busy=%b count=%0d ovf=%b, need 1 4 1", busy_o, count_o, overflow_o);
    end
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (valid_o !== 1'b1 || b_o !== 8'(i)) begin
        errors++;
        $display("FAIL drain_%0d: valid=%b b=%0d, need 1 %0d", i, valid_o, b_o, i);
      end
      @(negedge tb_clk);
    end
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || count_o !== 3'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drained: valid=%b count=%0d busy=%b, need 0 0 0", valid_o, count_o, busy_o);
    end
    // Dropped draw still loaded the colour shadow (b=5)
    issue(4'd5, 25'd1);
    checks++;
    if (shape_o !== 2'b01 || b_o !== 8'd5 || r_o !== 8'd0) begin
      errors++;
      $display("FAIL drop_colour: shape=%b r=%0d b=%0d, need 01 0 5", shape_o, r_o, b_o);
    end
    pop_cycles(1);
    clr_err_i = 1'b1;
    @(negedge tb_clk);
    clr_err_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_overflow: ovf=%b, need 0", overflow_o);
    end
  endtask

  task automatic test_full_push_pop();
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) issue(4'd4, 25'(8'h10 + i));
    @(negedge tb_clk);
    opcode_i     = 4'd4;
    parameters_i = 25'h15;
    command_i    = 1'b1;
    ready_i      = 1'b1;
    @(negedge tb_clk);
    command_i    = 1'b0;
    ready_i      = 1'b0;
    checks++;
    if (count_o !== 3'd4 || busy_o !== 1'b1 || overflow_o !== 1'b0 || b_o !== 8'h12) begin
      errors++;
      $display("FAIL push_pop_full: count=%0d busy=%b ovf=%b b=%h, need 4 1 0 12",
               count_o, busy_o, overflow_o, b_o);
    end
    ready_i = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      checks++;
      if (valid_o !== 1'b1 || b_o !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL wrap_order_%0d: valid=%b b=%h, need 1 %h", i, valid_o, b_o, 8'(8'h10 + i));
      end
      @(negedge tb_clk);
    end
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL wrap_empty: valid=%b count=%0d, need 0 0", valid_o, count_o);
    end
  endtask

  task automatic test_illegal();
    issue(4'd9, 25'h1FFFFFF);
    checks++;
    if (illegal_o !== 1'b1 || count_o !== 3'd0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal: ill=%b count=%0d valid=%b, need 1 0 0", illegal_o, count_o, valid_o);
    end
    clr_err_i = 1'b1;
    @(negedge tb_clk);
    clr_err_i = 1'b0;
    checks++;
    if (illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_illegal: ill=%b, need 0", illegal_o);
    end
    @(negedge tb_clk);
    opcode_i  = 4'd12;
    command_i = 1'b1;
    clr_err_i = 1'b1;
    @(negedge tb_clk);
    command_i = 1'b0;
    clr_err_i = 1'b0;
    opcode_i  = 4'd0;
    checks++;
    if (illegal_o !== 1'b1 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_vs_event: ill=%b ovf=%b, need 1 0", illegal_o, overflow_o);
    end
  endtask

  initial begin
    rst          = 1'b1;
    opcode_i     = 4'd0;
    parameters_i = '0;
    command_i    = 1'b0;
    clr_err_i    = 1'b0;
    ready_i      = 1'b0;
    repeat (2) @(negedge tb_clk);
    rst = 1'b0;
    @(negedge tb_clk);
    test_reset();
    test_basic_line();
    test_circle();
    test_fill_overflow();
    test_full_push_pop();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_instruction_queue_decoder.md
Name: gpu_instruction_queue_decoder

Overview:
Parametrised, buffered successor to the combinational instruction decoder. It consumes the opcode/parameters/command_i strobe from gpu_apb_interface and keeps XY1, XY2 and colour shadow registers. On each draw opcode it packs a complete draw packet into an internal FIFO, and a downstream raster engine pops packets with a valid/ready handshake. It provides back-pressure (busy_o), occupancy, and sticky overflow/illegal-opcode flags.

Parameters:
WIDTH_BITS, 10, x and radius width; elaboration error unless WIDTH_BITS+HEIGHT_BITS <= 25.
HEIGHT_BITS, 10, y width.
CHANNEL_BITS, 8, per-colour channel width; elaboration error unless 3*CHANNEL_BITS <= 25.
DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
opcode_i  in  4  instruction opcode
parameters_i  in  25  instruction payload
command_i  in  1  one-cycle strobe; opcode/parameters valid
clr_err_i  in  1  clears sticky flags
x1_o, x2_o  out  WIDTH_BITS  head packet coordinates
y1_o, y2_o  out  HEIGHT_BITS  head packet coordinates
rad_o  out  WIDTH_BITS  head packet radius
r_o, g_o, b_o  out  CHANNEL_BITS  head packet colour
shape_o  out  2  00 line, 01 circle, 10 rect
valid_o  out  1  FIFO non-empty
ready_i  in  1  downstream pops when valid_o && ready_i
busy_o  out  1  FIFO full
count_o  out  $clog2(DEPTH)+1  occupancy
overflow_o  out  1  sticky: draw dropped because FIFO full
illegal_o  out  1  sticky: unknown opcode received

Behaviour:
- Reset: all shadow registers, FIFO pointers, count_o, flags and all outputs go to 0; valid_o=0, busy_o=0. Reset mid-packet flushes the FIFO with no partial pop.
- All state changes on posedge clk. command_i is sampled only at the edge.
- Field extraction (P = parameters_i):
  - xy = {P[WIDTH_BITS+HEIGHT_BITS-1:HEIGHT_BITS], P[HEIGHT_BITS-1:0]}.
  - colour = r P[3C-1:2C], g P[2C-1:C], b P[C-1:0], where C = CHANNEL_BITS.
  - rad = P[WIDTH_BITS-1:0]. Unused upper bits are ignored.
- Opcodes:
  - 0 NOP: no effect.
  - 1 SET_XY1: load x1/y1 shadow.
  - 2 SET_XY2: load x2/y2 shadow.
  - 3 SET_COLOR: load colour shadow.
  - 4 DRAW_LINE: push {line, x1, y1, x2, y2, rad=0, colour from P}; also load colour shadow.
  - 5 DRAW_CIRCLE: push {circle, x1, y1, x2, y2, rad from P, colour shadow}.
  - 6 FILL_RECT: push {rect, x1, y1, x2, y2, rad=0, colour from P}; also load colour shadow.
  - 7–15: no push, set illegal_o.
- Packets snapshot shadow values as they stood before the edge. A SET followed by a DRAW on the next strobe sees the new value.
- Push accepted when a draw strobe arrives and (count < DEPTH, or a pop occurs in the same cycle). Otherwise the packet is dropped, overflow_o is set, and FIFO and shadows are unchanged. Colour-shadow loads on DRAW still occur.
- Push with pop: count unchanged; both pointers advance.
- Push with no pop: count+1. Pop with no push: count-1.
- Pointers wrap modulo DEPTH.
- Latency: a push into an empty FIFO gives valid_o=1 with packet fields on the outputs the next cycle.
- Head outputs are driven from the read-pointer entry. They are held stable while valid_o && !ready_i.
- When empty, outputs show the last popped (stale) entry and valid_o=0. A pop while empty is ignored.
- busy_o = (count_o == DEPTH), registered together with count.
- clr_err_i clears both flags next edge. If an error event and clr_err_i occur in the same cycle, the flag ends up set.
- Strobes held high for multiple cycles are treated as one command per cycle (no edge detection).

Test Plan:
- Reset sequence: assert rst mid-stream with 3 entries queued -> next cycle count_o=0, valid_o=0, all flags and outputs 0.
- Basic line: SET_XY1 P=0; SET_XY2 P={x=6, y=7} (0x1807); DRAW_LINE P=0x0ABD3E -> one cycle later valid_o=1, shape_o=00, x1=0, y1=0, x2=6, y2=7, r=0x0A, g=0xBD, b=0x3E.
- Circle uses colour shadow: SET_COLOR P=0x112233; SET_XY1 {5,9}; DRAW_CIRCLE P=20 -> packet {circle, x1=5, y1=9, rad=20, r=0x11, g=0x22, b=0x33}.
- Fill and overflow: ready_i=0, issue 5 DRAW_LINE with b=1..5 (DEPTH=4) -> busy_o=1 after the 4th, overflow_o=1 after the 5th, count_o=4. Then drain with ready_i=1 -> pops b=1,2,3,4 in order, one per cycle.
- Full with simultaneous push and pop: with count=4, a DRAW strobe in the same cycle as a pop -> accepted, count stays 4, overflow_o stays 0, wrap-around order preserved.
- Illegal opcode and clear: opcode 9 -> illegal_o=1, count unchanged. clr_err_i pulse -> 0. clr_err_i together with opcode 12 -> illegal_o=1.
